// File: rtl/fm_tile_pingpong_buffer.sv
// Double-buffered feature-map tile store.
// The host loads one bank while the convolution array streams the other.
// The read port is ready/valid and tolerates consumer backpressure.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for rd_start on a full read bank
// FETCH  | issuing tile addresses 0..cnt-1 into the read pipeline
// DRAIN  | all addresses issued; waiting for the last beat to be accepted
module fm_tile_pingpong_buffer #(
    parameter int PARA_X     = 3,
    parameter int PARA_Y     = 3,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0]               wr_addr,
    input  logic                                wr_en,
    input  logic                                wr_done,
    output logic                                wr_bank_free,
    output logic                                bank_ready,
    input  logic                                rd_start,
    input  logic [ADDR_WIDTH:0]                 rd_count,
    input  logic                                rd_release,
    output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0]               rd_addr,
    output logic                                rd_valid,
    input  logic                                rd_ready,
    output logic                                rd_last,
    output logic                                rd_busy,
    output logic                                overflow_err
);

    localparam int TW    = PARA_X * PARA_Y * DATA_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    // Both banks share one array; the bank select is the top address bit.
    logic [TW-1:0] mem_q [0:2*DEPTH-1];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  rel_q, rel_d;
    logic [ADDR_WIDTH-1:0] iss_q, iss_d;
    logic [1:0]            full_q, full_d;
    logic                  wb_q, wb_d;
    logic                  rb_q, rb_d;
    logic                  ovf_q, ovf_d;

    // Stage 1 holds the issued RAM address; stage 2 is the output register.
    logic                  s1_valid_q, s1_last_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q;
    logic                  rd_valid_q, rd_last_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [TW-1:0]         rd_data_q;

    logic                  wr_ok, wr_fire, seal, adv;
    logic                  issue, issue_last, rel_now;
    logic [ADDR_WIDTH:0]   cnt_clamp;

    assign wr_ok     = !full_q[wb_q];
    assign wr_fire   = wr_en && wr_ok;
    assign seal      = wr_done && wr_ok;
    // The whole read pipeline moves together whenever the output slot can take a beat.
    assign adv       = !rd_valid_q || rd_ready;
    assign cnt_clamp = (rd_count > DEPTH_C) ? DEPTH_C : rd_count;

    // Tile storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[{wb_q, wr_addr}] <= wr_data;
        end
    end

    // Read FSM next state plus bank bookkeeping.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rel_d      = rel_q;
        iss_d      = iss_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        rel_now    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd_start && full_q[rb_q]) begin
                    cnt_d = cnt_clamp;
                    rel_d = rd_release;
                    iss_d = '0;
                    if (cnt_clamp == '0) begin
                        rel_now = rd_release;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (adv) begin
                    issue = 1'b1;
                    iss_d = iss_q + 1'b1;
                    if ({1'b0, iss_q} == cnt_q - 1'b1) begin
                        issue_last = 1'b1;
                        state_d    = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (rd_valid_q && rd_ready && rd_last_q) begin
                    state_d = S_IDLE;
                    rel_now = rel_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A seal and a release never target the same bank: one needs it empty, the other full.
        full_d = full_q;
        if (seal)    full_d[wb_q] = 1'b1;
        if (rel_now) full_d[rb_q] = 1'b0;
        wb_d  = wb_q ^ seal;
        rb_d  = rb_q ^ rel_now;
        ovf_d = ovf_q | ((wr_en | wr_done) & full_q[wb_q]);
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rel_q   <= 1'b0;
            iss_q   <= '0;
            full_q  <= '0;
            wb_q    <= 1'b0;
            rb_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
            iss_q   <= iss_d;
            full_q  <= full_d;
            wb_q    <= wb_d;
            rb_q    <= rb_d;
            ovf_q   <= ovf_d;
        end
    end

    // Two-stage read pipeline: address register, then RAM data into the output register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_addr_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
        end else if (adv) begin
            s1_valid_q <= issue;
            s1_last_q  <= issue_last;
            s1_addr_q  <= iss_q;
            rd_valid_q <= s1_valid_q;
            rd_last_q  <= s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                rd_addr_q <= s1_addr_q;
                rd_data_q <= mem_q[{rb_q, s1_addr_q}];
            end
        end
    end

    assign wr_bank_free = !full_q[wb_q];
    assign bank_ready   = full_q[rb_q];
    assign rd_busy      = (state_q != S_IDLE);
    assign overflow_err = ovf_q;
    assign rd_data      = rd_data_q;
    assign rd_addr      = rd_addr_q;
    assign rd_valid     = rd_valid_q;
    assign rd_last      = rd_last_q;

endmodule

// File: tb/tb_fm_tile_pingpong_buffer.sv
// Bench for fm_tile_pingpong_buffer: directed sequences, a table of read
// commands, and a randomized run against a bank/queue reference model.
module tb_fm_tile_pingpong_buffer;

    localparam int PX    = 3;
    localparam int PY    = 3;
    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int TW    = PX * PY * DW;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [TW-1:0] wr_data = '0;
    logic [AW-1:0] wr_addr = '0;
    logic          wr_en = 1'b0, wr_done = 1'b0;
    logic          wr_bank_free, bank_ready;
    logic          rd_start = 1'b0;
    logic [AW:0]   rd_count = '0;
    logic          rd_release = 1'b0;
    logic [TW-1:0] rd_data;
    logic [AW-1:0] rd_addr;
    logic          rd_valid, rd_last, rd_busy, overflow_err;
    logic          rd_ready = 1'b1;

    always #5 clk = ~clk;

    fm_tile_pingpong_buffer #(.PARA_X(PX), .PARA_Y(PY), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en), .wr_done(wr_done),
        .wr_bank_free(wr_bank_free), .bank_ready(bank_ready),
        .rd_start(rd_start), .rd_count(rd_count), .rd_release(rd_release),
        .rd_data(rd_data), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_last(rd_last), .rd_busy(rd_busy), .overflow_err(overflow_err)
    );

    // Reference model: two banks of tiles, full flags, bank pointers, expected beat queue.
    typedef struct {
        logic [AW-1:0] addr;
        logic [TW-1:0] data;
        bit            last;
    } beat_t;

    beat_t         expq[$];
    logic [TW-1:0] mbank [2][DEPTH];
    bit            mfull [2];
    bit            mwb, mrb, movf, m_busy, mrel;

    int n_cmp = 0, n_err = 0, n_beats = 0;
    bit chk_en = 1'b0;
    bit stall_prev = 1'b0;
    logic [TW-1:0] pdata;
    logic [AW-1:0] paddr;
    logic          plast;

    typedef struct {
        int cnt;
        bit rel;
        int beats;
        bit ready_after;
    } vec_t;
    vec_t vt[7];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [TW-1:0] tile_k(input int k);
        logic [TW-1:0] t;
        logic [15:0]   e;
        e = 16'h3c00 + 16'(k);
        for (int i = 0; i < PX * PY; i++) t[i*DW +: DW] = e;
        return t;
    endfunction

    function automatic logic [TW-1:0] rand_tile();
        logic [TW-1:0] t;
        for (int i = 0; i < PX * PY; i++) t[i*DW +: DW] = DW'($urandom);
        return t;
    endfunction

    // Advances the model by the events that the coming rising edge will apply.
    task automatic model_step();
        bit    seal_now, rel_now;
        int    c;
        beat_t b;
        seal_now = 1'b0;
        rel_now  = 1'b0;
        if (!rst) begin
            mfull[0] = 1'b0; mfull[1] = 1'b0;
            mwb = 1'b0; mrb = 1'b0; movf = 1'b0; m_busy = 1'b0;
            expq.delete();
            stall_prev = 1'b0;
            return;
        end
        if ((wr_en || wr_done) && mfull[mwb]) begin
            movf = 1'b1;
        end else begin
            if (wr_en) mbank[mwb][wr_addr] = wr_data;
            seal_now = wr_done;
        end
        if (rd_start && !m_busy && mfull[mrb]) begin
            c = (int'(rd_count) > DEPTH) ? DEPTH : int'(rd_count);
            if (c == 0) begin
                rel_now = rd_release;
            end else begin
                m_busy = 1'b1;
                mrel   = rd_release;
                for (int i = 0; i < c; i++) begin
                    beat_t nb;
                    nb.addr = AW'(i);
                    nb.data = mbank[mrb][i];
                    nb.last = (i == c - 1);
                    expq.push_back(nb);
                end
            end
        end
        if (rd_valid && rd_ready) begin
            if (expq.size() == 0) begin
                check("unexpected_beat", 256'(1), 256'(0));
            end else begin
                b = expq.pop_front();
                check("beat", 256'({rd_addr, rd_last, rd_data}), 256'({b.addr, b.last, b.data}));
                n_beats++;
                if (b.last) begin
                    m_busy = 1'b0;
                    if (mrel) rel_now = 1'b1;
                end
            end
        end
        if (seal_now) begin mfull[mwb] = 1'b1; mwb = ~mwb; end
        if (rel_now)  begin mfull[mrb] = 1'b0; mrb = ~mrb; end
        stall_prev = rd_valid && !rd_ready;
        pdata = rd_data; paddr = rd_addr; plast = rd_last;
    endtask

    // One clock: check status and stall stability at the falling edge, step the model, then the edge.
    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            check("bank_ready",   256'(bank_ready),   256'(mfull[mrb]));
            check("wr_bank_free", 256'(wr_bank_free), 256'(!mfull[mwb]));
            check("overflow_err", 256'(overflow_err), 256'(movf));
            check("rd_busy",      256'(rd_busy),      256'(m_busy));
            if (stall_prev)
                check("stall_hold", 256'({rd_valid, rd_addr, rd_last, rd_data}),
                      256'({1'b1, paddr, plast, pdata}));
        end
        model_step();
        @(posedge clk);
        #1;
        chk_en  = 1'b1;
        wr_en   = 1'b0;
        wr_done = 1'b0;
        rd_start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic fill(input int n, input bit planned);
        for (int k = 0; k < n; k++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(k);
            wr_data = planned ? tile_k(k) : rand_tile();
            tick();
        end
        wr_done = 1'b1;
        tick();
    endtask

    task automatic start_read(input int cnt, input bit rel);
        rd_count   = (AW + 1)'(cnt);
        rd_release = rel;
        rd_start   = 1'b1;
        tick();
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        rd_ready = 1'b1;
        while ((m_busy || expq.size() != 0) && k < budget) begin
            tick();
            k++;
        end
        if (m_busy || expq.size() != 0) check("drain_timeout", 256'(1), 256'(0));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, consec;
        vt[0] = '{0,   1'b1, 0,  1'b0};
        vt[1] = '{0,   1'b0, 0,  1'b1};
        vt[2] = '{1,   1'b1, 1,  1'b0};
        vt[3] = '{5,   1'b0, 5,  1'b1};
        vt[4] = '{64,  1'b1, 64, 1'b0};
        vt[5] = '{65,  1'b1, 64, 1'b0};
        vt[6] = '{127, 1'b0, 64, 1'b1};

        // Reset state.
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        check("rst_rd_valid",     256'(rd_valid),     256'(0));
        check("rst_wr_bank_free", 256'(wr_bank_free), 256'(1));
        check("rst_bank_ready",   256'(bank_ready),   256'(0));
        check("rst_rd_busy",      256'(rd_busy),      256'(0));
        check("rst_overflow",     256'(overflow_err), 256'(0));
        check("rst_rd_last",      256'(rd_last),      256'(0));
        check("rst_rd_addr",      256'(rd_addr),      256'(0));
        check("rst_rd_data",      256'(rd_data),      256'(0));

        // Basic 9-tile load and stream with latency and throughput checks.
        fill(9, 1'b1);
        b0 = n_beats;
        start_read(9, 1'b1);
        check("lat_t1_valid", 256'(rd_valid), 256'(0));
        tick();
        check("lat_t2_valid", 256'(rd_valid), 256'(0));
        tick();
        check("lat_first_valid", 256'(rd_valid), 256'(1));
        check("lat_first_data",  256'({rd_addr, rd_data}), 256'({AW'(0), tile_k(0)}));
        consec = 0;
        for (int i = 0; i < 9; i++) begin
            if (rd_valid) consec++;
            tick();
        end
        check("basic_consecutive", 256'(consec), 256'(9));
        check("basic_beats", 256'(n_beats - b0), 256'(9));
        check("basic_valid_after", 256'(rd_valid), 256'(0));
        check("basic_bank_ready_after", 256'(bank_ready), 256'(0));
        check("basic_free_after", 256'(wr_bank_free), 256'(1));

        // Ping-pong: load the second bank while the first streams.
        fill(4, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                rd_count = 7'd4; rd_release = 1'b1; rd_start = 1'b1;
            end
            wr_en   = (i < 4);
            wr_addr = AW'(i);
            wr_data = rand_tile();
            wr_done = (i == 4);
            rd_ready = (i % 2 == 1);
            tick();
        end
        drain(50);
        check("pp_no_overflow", 256'(overflow_err), 256'(0));
        check("pp_next_ready", 256'(bank_ready), 256'(1));
        b0 = n_beats;
        start_read(4, 1'b1);
        drain(50);
        check("pp_second_beats", 256'(n_beats - b0), 256'(4));

        // Backpressure on a 6-tile read.
        fill(6, 1'b0);
        b0 = n_beats;
        start_read(6, 1'b1);
        for (int k = 0; k < 60 && (m_busy || expq.size() != 0); k++) begin
            rd_ready = (k % 3 == 0);
            tick();
        end
        drain(10);
        check("bp_beats", 256'(n_beats - b0), 256'(6));

        // Retain mode: two retained reads, then a releasing one.
        fill(4, 1'b0);
        for (int r = 0; r < 3; r++) begin
            b0 = n_beats;
            start_read(4, (r == 2));
            drain(50);
            check("retain_beats", 256'(n_beats - b0), 256'(4));
            check("retain_bank_ready", 256'(bank_ready), 256'(r < 2));
        end

        // Overflow: both banks sealed, then a stray write.
        fill(3, 1'b0);
        fill(3, 1'b0);
        wr_en = 1'b1; wr_addr = '0; wr_data = rand_tile();
        tick();
        check("ovf_set", 256'(overflow_err), 256'(1));
        start_read(3, 1'b1);
        drain(50);
        start_read(3, 1'b1);
        drain(50);
        start_read(4, 1'b1);
        check("empty_start_busy0", 256'(rd_busy), 256'(0));
        tick();
        check("empty_start_busy1", 256'(rd_busy), 256'(0));
        check("ovf_sticky", 256'(overflow_err), 256'(1));

        // Reset in the middle of a stream.
        do_reset();
        fill(20, 1'b0);
        start_read(20, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        check("mid_valid_before", 256'(rd_valid), 256'(1));
        rst = 1'b0;
        tick();
        check("mid_rst_valid", 256'(rd_valid), 256'(0));
        check("mid_rst_bank_ready", 256'(bank_ready), 256'(0));
        check("mid_rst_free", 256'(wr_bank_free), 256'(1));
        check("mid_rst_busy", 256'(rd_busy), 256'(0));
        rst = 1'b1;

        // Table of read commands, each on a freshly reset, fully loaded bank.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            fill(DEPTH, 1'b0);
            b0 = n_beats;
            start_read(vt[v].cnt, vt[v].rel);
            drain(200);
            check("vec_beats", 256'(n_beats - b0), 256'(vt[v].beats));
            check("vec_bank_ready", 256'(bank_ready), 256'(vt[v].ready_after));
            check("vec_valid_idle", 256'(rd_valid), 256'(0));
        end

        // Load every address of both banks so random reads never touch unwritten tiles.
        do_reset();
        fill(DEPTH, 1'b0);
        fill(DEPTH, 1'b0);
        start_read(DEPTH, 1'b1);
        drain(200);
        start_read(DEPTH, 1'b1);
        drain(200);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            wr_en      = ($urandom_range(0, 1) == 1);
            wr_addr    = AW'($urandom_range(0, DEPTH - 1));
            wr_data    = rand_tile();
            wr_done    = ($urandom_range(0, 15) == 0);
            rd_start   = ($urandom_range(0, 7) == 0);
            rd_count   = ($urandom_range(0, 9) == 0) ? (AW + 1)'($urandom_range(60, 70))
                                                     : (AW + 1)'($urandom_range(0, 12));
            rd_release = ($urandom_range(0, 3) != 0);
            rd_ready   = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fm_tile_pingpong_buffer.md
Name: fm_tile_pingpong_buffer

Overview:
- Parametrised, double-buffered feature-map tile store between the host-side init loader and the PARA_X x PARA_Y convolution array.
- Generalises the single-bank "write tiles, then pulse done" init flow:
  - configurable tile geometry and depth;
  - two banks, so the next slice loads while the current one is consumed;
  - ready/valid streaming read port with backpressure;
  - optional bank retention for re-reading across kernel batches.

Parameters:
- PARA_X, 3, tile columns.
- PARA_Y, 3, tile rows.
- DATA_WIDTH, 16, element width (float16; never interpreted).
- ADDR_WIDTH, 6, tile address width; each bank holds DEPTH = 2**ADDR_WIDTH tiles.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- wr_data  in  PARA_X*PARA_Y*DATA_WIDTH  tile to store.
- wr_addr  in  ADDR_WIDTH  tile index in the current write bank.
- wr_en  in  1  write strobe.
- wr_done  in  1  pulse: current write bank complete.
- wr_bank_free  out  1  current write bank accepts writes.
- bank_ready  out  1  current read bank is full.
- rd_start  in  1  pulse: stream current read bank.
- rd_count  in  ADDR_WIDTH+1  tiles to stream from address 0; sampled on an accepted rd_start.
- rd_release  in  1  sampled with rd_start. 1 = free the bank after streaming; 0 = retain it.
- rd_data  out  PARA_X*PARA_Y*DATA_WIDTH  streamed tile.
- rd_addr  out  ADDR_WIDTH  index of the tile on rd_data.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts the beat.
- rd_last  out  1  final beat of the stream.
- rd_busy  out  1  read FSM not IDLE.
- overflow_err  out  1  sticky error flag.

Behaviour:
- Reset (rst==0 at a clock edge):
  - full[1:0]=0, wb=0, rb=0, FSM=IDLE.
  - All outputs 0 except wr_bank_free=1.
  - RAM contents are not cleared.
  - Reset mid-stream aborts immediately; rd_valid drops at that edge.
- Write side:
  - wr_en with full[wb]==0 writes bank wb at wr_addr.
  - wr_done with full[wb]==0 sets full[wb] and toggles wb.
  - wr_en and wr_done in the same cycle: the write lands first, then the bank is sealed.
  - wr_en or wr_done while full[wb]==1: dropped, overflow_err set (sticky until reset).
  - wr_bank_free = !full[wb].
- Read FSM states IDLE, FETCH, DRAIN:
  - IDLE: rd_start with full[rb]==1 latches cnt=min(rd_count, DEPTH) and rel=rd_release.
    - cnt==0: release (if rel) in the same cycle, stay IDLE, no beats.
    - Otherwise go to FETCH with address 0.
  - IDLE: rd_start with full[rb]==0 is ignored; no error.
  - FETCH: RAM read enable = !rd_valid || rd_ready.
    - Each enabled cycle issues the next address.
    - Synchronous RAM: data lands in the output register next cycle with rd_valid=1.
    - After issuing address cnt-1, go to DRAIN.
  - DRAIN: on rd_valid && rd_ready && rd_last, go to IDLE.
    - If rel: clear full[rb] and toggle rb in that cycle.
    - If !rel: bank and rb are unchanged, so the bank can be re-read.
- Output register behaviour:
  - rd_data, rd_addr and rd_last hold stable while rd_valid && !rd_ready.
  - rd_last=1 exactly on the beat with rd_addr==cnt-1.
- Timing:
  - Latency: rd_start accepted at edge T gives first rd_valid after edge T+2.
  - Throughput: 1 tile/cycle while rd_ready=1.
- bank_ready = full[rb]. rd_busy = (FSM != IDLE).
- Simultaneous events:
  - A read release and a wr_done on the other bank in the same cycle both take effect.
  - The write side sees the freed bank on the following cycle.
- Writes into the bank being read are impossible, because that bank is full.
- The block performs no arithmetic. rd_count wider than DEPTH is clamped.

Test Plan:
- Reset, write tiles 0..8 (tile k = all elements 16'h3c00+k), wr_done, rd_start rd_count=9 rd_release=1, rd_ready=1 -> rd_valid high 9 consecutive cycles starting T+2; rd_addr 0..8 in order with matching data; rd_last on addr 8; afterwards bank_ready=0, wr_bank_free=1.
- Ping-pong: fill bank0 (4 tiles), wr_done; while streaming bank0, fill bank1 and wr_done -> no overflow_err; bank1 streams immediately after the bank0 release with the correct data.
- Backpressure: rd_ready toggled 1,0,0,1,... during a 6-tile read -> rd_data/rd_addr stable while stalled; exactly 6 accepted beats with no duplicates or skips.
- Retain mode: rd_release=0, read 4 tiles, then rd_start again -> identical 4-beat stream; bank_ready stays 1 until a third read with rd_release=1.
- Overflow: fill and seal both banks, then wr_en at addr 0 -> overflow_err=1, bank contents unchanged on readback; rd_start on an empty bank -> rd_busy stays 0.
- Edge cases: rd_count=0 -> bank released with no rd_valid; rd_count=DEPTH+1 -> exactly DEPTH beats; rst=0 mid-stream -> rd_valid=0, full=0 and wr_bank_free=1 after that edge.
